cra_launch_ctrl: RTL and testbench



---
 rtl/cra_launch_pkg.sv | 28 ++
 rtl/cra_launch_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_cra_launch_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cra_launch_pkg.sv
// Shared types and constants for the CRA launch sequencer.
package cra_launch_pkg;

    localparam int unsigned CRA_WORD_W = 64;
    localparam int unsigned CRA_ADDR_W = 4;

    localparam int unsigned DEF_START_ADDR    = 1;
    localparam int unsigned DEF_IRQ_EN_ADDR   = 2;
    localparam int unsigned DEF_IRQ_STAT_ADDR = 3;
    localparam int unsigned DEF_RESULT_ADDR   = 4;
    localparam int unsigned DEF_ARG_BASE      = 5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_IRQEN  = 3'd1,
        ST_WR_ARG    = 3'd2,
        ST_WR_START  = 3'd3,
        ST_WAIT_IRQ  = 3'd4,
        ST_RD_RESULT = 3'd5,
        ST_CLR_IRQ   = 3'd6,
        ST_DONE      = 3'd7
    } cra_launch_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cra_launch_ctrl.sv
// Launch sequencer driving an HLS component's CRA slave: program args, start, await irq, read result.
// Optional watchdog compiled in with `define CRA_LAUNCH_TIMEOUT_EN.
module cra_launch_ctrl
    import cra_launch_pkg::*;
#(
    parameter int unsigned NUM_ARGS       = 2,
    parameter int unsigned START_ADDR     = DEF_START_ADDR,
    parameter int unsigned IRQ_EN_ADDR    = DEF_IRQ_EN_ADDR,
    parameter int unsigned IRQ_STAT_ADDR  = DEF_IRQ_STAT_ADDR,
    parameter int unsigned RESULT_ADDR    = DEF_RESULT_ADDR,
    parameter int unsigned ARG_BASE       = DEF_ARG_BASE,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 32'd16777216
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start_valid,
    output logic                           start_ready,
    input  logic [NUM_ARGS*CRA_WORD_W-1:0] start_args,
    output logic                           result_valid,
    input  logic                           result_ready,
    output logic [CRA_WORD_W-1:0]          result_data,
    output logic [31:0]                    result_cycles,
    output logic                           result_timeout,
    output logic                           busy,
    input  logic                           done_irq,
    output logic                           avs_cra_read,
    output logic                           avs_cra_write,
    output logic [CRA_ADDR_W-1:0]          avs_cra_address,
    output logic [CRA_WORD_W-1:0]          avs_cra_writedata,
    output logic [7:0]                     avs_cra_byteenable,
    input  logic [CRA_WORD_W-1:0]          avs_cra_readdata
);

    localparam int unsigned LAT_W = $clog2(READ_LATENCY + 1);

`ifdef CRA_LAUNCH_TIMEOUT_EN
    localparam logic WDOG_EN = 1'b1;
`else
    localparam logic WDOG_EN = 1'b0;
`endif

    cra_launch_state_t             state_r, state_s;
    logic [CRA_ADDR_W-1:0]         arg_idx_r, arg_idx_s;
    logic [31:0]                   cnt_r, cnt_s, cnt_inc_s;
    logic [LAT_W-1:0]              lat_r, lat_s;
    logic [NUM_ARGS*CRA_WORD_W-1:0] args_r, args_s;
    logic                          timeout_r, timeout_s, timeout_hit_s;
    logic [CRA_WORD_W-1:0]         data_r, data_s;
    logic                          start_ready_r, busy_r, valid_r;
    logic                          rd_r, rd_s, wr_r, wr_s;
    logic [CRA_ADDR_W-1:0]         addr_r, addr_s;
    logic [CRA_WORD_W-1:0]         wdata_r, wdata_s;
    logic [7:0]                    be_r;

    // Next-state, datapath next values and next CRA bus values (registered below).
    always_comb begin
        state_s       = state_r;
        arg_idx_s     = arg_idx_r;
        cnt_s         = cnt_r;
        cnt_inc_s     = sat_inc32(cnt_r);
        lat_s         = lat_r;
        args_s        = args_r;
        timeout_s     = timeout_r;
        timeout_hit_s = 1'b0;
        data_s        = data_r;
        rd_s          = 1'b0;
        wr_s          = 1'b0;
        addr_s        = '0;
        wdata_s       = '0;

        case (state_r)
            ST_IDLE: begin
                if (start_valid && start_ready_r) begin
                    state_s   = ST_WR_IRQEN;
                    args_s    = start_args;
                    arg_idx_s = '0;
                    cnt_s     = 32'd0;
                    timeout_s = 1'b0;
                    data_s    = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR_IRQEN: begin
                state_s   = ST_WR_ARG;
                arg_idx_s = '0;
            end
            ST_WR_ARG: begin
                if (arg_idx_r == CRA_ADDR_W'(NUM_ARGS - 1)) begin
                    state_s = ST_WR_START;
                end else begin
                    arg_idx_s = arg_idx_r + 4'd1;
                end
            end
            ST_WR_START: state_s = ST_WAIT_IRQ;
            ST_WAIT_IRQ: begin
                cnt_s         = cnt_inc_s;
                timeout_hit_s = WDOG_EN && (cnt_inc_s >= TIMEOUT_CYCLES);
                // done_irq has priority over a simultaneous watchdog expiry
                if (done_irq) begin
                    state_s = ST_RD_RESULT;
                    lat_s   = '0;
                end else if (timeout_hit_s) begin
                    state_s   = ST_CLR_IRQ;
                    timeout_s = 1'b1;
                end else begin
                    state_s = ST_WAIT_IRQ;
                end
            end
            ST_RD_RESULT: begin
                if (lat_r == LAT_W'(READ_LATENCY)) begin
                    data_s  = avs_cra_readdata;
                    state_s = ST_CLR_IRQ;
                end else begin
                    lat_s = lat_r + LAT_W'(1);
                end
            end
            ST_CLR_IRQ: state_s = ST_DONE;
            ST_DONE: begin
                if (result_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase

        // Bus values for the upcoming cycle; args shift down so word 0 is always the next to send.
        case (state_s)
            ST_WR_IRQEN: begin
                wr_s    = 1'b1;
                addr_s  = CRA_ADDR_W'(IRQ_EN_ADDR);
                wdata_s = 64'd1;
            end
            ST_WR_ARG: begin
                wr_s    = 1'b1;
                addr_s  = CRA_ADDR_W'(ARG_BASE) + arg_idx_s;
                wdata_s = args_r[CRA_WORD_W-1:0];
                args_s  = args_r >> CRA_WORD_W;
            end
            ST_WR_START: begin
                wr_s    = 1'b1;
                addr_s  = CRA_ADDR_W'(START_ADDR);
                wdata_s = 64'd1;
            end
            ST_RD_RESULT: begin
                if (state_r == ST_WAIT_IRQ) begin
                    rd_s   = 1'b1;
                    addr_s = CRA_ADDR_W'(RESULT_ADDR);
                end else begin
                    rd_s = 1'b0;
                end
            end
            ST_CLR_IRQ: begin
                wr_s    = 1'b1;
                addr_s  = CRA_ADDR_W'(IRQ_STAT_ADDR);
                wdata_s = 64'd1;
            end
            default: begin
                rd_s = 1'b0;
                wr_s = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            arg_idx_r     <= '0;
            cnt_r         <= 32'd0;
            lat_r         <= '0;
            args_r        <= '0;
            timeout_r     <= 1'b0;
            data_r        <= '0;
            start_ready_r <= 1'b0;
            busy_r        <= 1'b0;
            valid_r       <= 1'b0;
            rd_r          <= 1'b0;
            wr_r          <= 1'b0;
            addr_r        <= '0;
            wdata_r       <= '0;
            be_r          <= 8'h00;
        end else begin
            state_r       <= state_s;
            arg_idx_r     <= arg_idx_s;
            cnt_r         <= cnt_s;
            lat_r         <= lat_s;
            args_r        <= args_s;
            timeout_r     <= timeout_s;
            data_r        <= data_s;
            start_ready_r <= (state_s == ST_IDLE);
            busy_r        <= (state_s != ST_IDLE);
            valid_r       <= (state_s == ST_DONE);
            rd_r          <= rd_s;
            wr_r          <= wr_s;
            addr_r        <= addr_s;
            wdata_r       <= wdata_s;
            be_r          <= (rd_s || wr_s) ? 8'hFF : 8'h00;
        end
    end

    assign start_ready        = start_ready_r;
    assign busy               = busy_r;
    assign result_valid       = valid_r;
    assign result_data        = data_r;
    assign result_cycles      = cnt_r;
    assign result_timeout     = timeout_r;
    assign avs_cra_read       = rd_r;
    assign avs_cra_write      = wr_r;
    assign avs_cra_address    = addr_r;
    assign avs_cra_writedata  = wdata_r;
    assign avs_cra_byteenable = be_r;

endmodule

// File: tb/tb_cra_launch_ctrl.sv
// Directed bench for cra_launch_ctrl: table of launches plus reset/timeout sequences.
module tb_cra_launch_ctrl;
    import cra_launch_pkg::*;

    localparam int unsigned NA = 2;
    localparam int unsigned RL = 3;
    localparam int unsigned TO = 16;

    logic              clock;
    logic              reset;
    logic              start_valid;
    logic              start_ready;
    logic [NA*64-1:0]  start_args;
    logic              result_valid;
    logic              result_ready;
    logic [63:0]       result_data;
    logic [31:0]       result_cycles;
    logic              result_timeout;
    logic              busy;
    logic              done_irq;
    logic              avs_cra_read;
    logic              avs_cra_write;
    logic [3:0]        avs_cra_address;
    logic [63:0]       avs_cra_writedata;
    logic [7:0]        avs_cra_byteenable;
    logic [63:0]       avs_cra_readdata;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [63:0] data;
        int          rel;
    } op_t;

    typedef struct {
        string       nm;
        logic [63:0] a0;
        logic [63:0] a1;
        int          d;
        bit          pre;
        logic [63:0] rdv;
        int          hold;
        logic [31:0] exp_cyc;
    } vec_t;

    vec_t vecs[4];

    cra_launch_ctrl #(
        .NUM_ARGS       (NA),
        .READ_LATENCY   (RL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .start_valid        (start_valid),
        .start_ready        (start_ready),
        .start_args         (start_args),
        .result_valid       (result_valid),
        .result_ready       (result_ready),
        .result_data        (result_data),
        .result_cycles      (result_cycles),
        .result_timeout     (result_timeout),
        .busy               (busy),
        .done_irq           (done_irq),
        .avs_cra_read       (avs_cra_read),
        .avs_cra_write      (avs_cra_write),
        .avs_cra_address    (avs_cra_address),
        .avs_cra_writedata  (avs_cra_writedata),
        .avs_cra_byteenable (avs_cra_byteenable),
        .avs_cra_readdata   (avs_cra_readdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] poison(input int rel);
        logic [63:0] p;
        p = 64'hBAD0_BAD0_0000_0000;
        return p ^ 64'(rel);
    endfunction

    // One full launch; d<0 means done_irq is never raised.
    task automatic run_txn(input string nm, input logic [63:0] a0, input logic [63:0] a1,
                           input int d, input bit pre, input logic [63:0] rdv, input int hold,
                           input logic [31:0] exp_cyc, input bit exp_to);
        op_t         ops[$];
        op_t         ex[$];
        int          rel, rd_rel, wait_start, valid_rel, viol, hviol, exp_valid;
        bit          got;
        logic [63:0] exp_data;

        exp_data   = exp_to ? 64'd0 : rdv;
        rd_rel     = -1;
        wait_start = -1;
        valid_rel  = -1;
        viol       = 0;
        hviol      = 0;
        done_irq   = pre;

        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (start_ready === 1'b1) got = 1'b1;
            else tick();
        end
        chk({nm, "_ready"}, 64'(got), 64'd1);

        start_args  = {a1, a0};
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        rel = 1;
        while (rel < 300 && valid_rel < 0) begin
            if (avs_cra_read && avs_cra_write) viol++;
            if (avs_cra_byteenable !== ((avs_cra_read || avs_cra_write) ? 8'hFF : 8'h00)) viol++;
            if (busy !== 1'b1 || start_ready !== 1'b0) viol++;
            if (avs_cra_write) begin
                ops.push_back('{1'b1, avs_cra_address, avs_cra_writedata, rel});
                if (avs_cra_address == 4'd1) wait_start = rel + 1;
            end
            if (avs_cra_read) begin
                ops.push_back('{1'b0, avs_cra_address, 64'd0, rel});
                rd_rel   = rel;
                done_irq = 1'b0;
            end
            if (d >= 0 && wait_start >= 0 && rel == wait_start + d) done_irq = 1'b1;
            avs_cra_readdata = (rd_rel >= 0 && rel == rd_rel + int'(RL)) ? rdv : poison(rel);
            if (result_valid) valid_rel = rel;
            else begin
                tick();
                rel++;
            end
        end
        done_irq = 1'b0;
        avs_cra_readdata = poison(0);

        ex.push_back('{1'b1, 4'd2, 64'd1, 1});
        ex.push_back('{1'b1, 4'd5, a0, 2});
        ex.push_back('{1'b1, 4'd6, a1, 3});
        ex.push_back('{1'b1, 4'd1, 64'd1, 4});
        if (exp_to) begin
            ex.push_back('{1'b1, 4'd3, 64'd1, int'(NA + 3 + TO)});
            exp_valid = int'(NA + 4 + TO);
        end else begin
            ex.push_back('{1'b0, 4'd4, 64'd0, int'(NA) + 4 + d});
            ex.push_back('{1'b1, 4'd3, 64'd1, int'(NA + 5 + RL) + d});
            exp_valid = int'(NA + 6 + RL) + d;
        end

        chk({nm, "_op_count"}, 64'(ops.size()), 64'(ex.size()));
        for (int i = 0; i < ex.size() && i < ops.size(); i++) begin
            chk($sformatf("%s_op%0d_kind", nm, i), 64'(ops[i].wr), 64'(ex[i].wr));
            chk($sformatf("%s_op%0d_addr", nm, i), 64'(ops[i].addr), 64'(ex[i].addr));
            if (ex[i].wr) chk($sformatf("%s_op%0d_data", nm, i), ops[i].data, ex[i].data);
            chk($sformatf("%s_op%0d_cycle", nm, i), 64'(ops[i].rel), 64'(ex[i].rel));
        end
        chk({nm, "_valid_cycle"}, 64'(valid_rel), 64'(exp_valid));
        chk({nm, "_bus_invariants"}, 64'(viol), 64'd0);
        chk({nm, "_result_data"}, result_data, exp_data);
        chk({nm, "_result_cycles"}, 64'(result_cycles), 64'(exp_cyc));
        chk({nm, "_result_timeout"}, 64'(result_timeout), 64'(exp_to));

        // hold the result with a decoy start offered; nothing may move
        start_args  = {64'hDEC0_DEC0_DEC0_DEC0, 64'hDEC1_DEC1_DEC1_DEC1};
        start_valid = (hold > 0);
        for (int h = 0; h < hold; h++) begin
            tick();
            if (result_valid !== 1'b1 || start_ready !== 1'b0 || busy !== 1'b1 ||
                result_data !== exp_data || result_cycles !== exp_cyc ||
                result_timeout !== exp_to || avs_cra_read || avs_cra_write) hviol++;
        end
        if (hold > 0) chk({nm, "_hold_stable"}, 64'(hviol), 64'd0);
        start_valid  = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk({nm, "_release"}, {61'd0, start_ready, result_valid, busy}, 64'b100);
    endtask

    task automatic reset_mid_arg();
        int traffic;
        chk("rst_mid_ready", 64'(start_ready), 64'd1);
        start_args  = {64'h7777, 64'h6666};
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        chk("rst_mid_in_wr_arg", {59'd0, avs_cra_write, avs_cra_address}, {59'd0, 1'b1, 4'd5});
        reset = 1'b1;
        tick();
        chk("rst_mid_cra_ctl", {50'd0, avs_cra_read, avs_cra_write, avs_cra_address, avs_cra_byteenable}, 64'd0);
        chk("rst_mid_wdata", avs_cra_writedata, 64'd0);
        chk("rst_mid_busy_ready", {62'd0, busy, start_ready}, 64'd0);
        reset = 1'b0;
        tick();
        chk("rst_mid_ready_after", {62'd0, start_ready, busy}, 64'b10);
        traffic = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (avs_cra_read || avs_cra_write) traffic++;
        end
        chk("rst_mid_no_traffic", 64'(traffic), 64'd0);
    endtask

    initial begin
        vecs[0] = '{"basic",   64'hA, 64'hB, 10, 1'b0, 64'h0123_4567_89AB_CDEF, 0, 32'd11};
        vecs[1] = '{"irq_pre", 64'h1, 64'h2, 0, 1'b1, 64'hFEDC_BA98_7654_3210, 0, 32'd1};
        vecs[2] = '{"hold",    64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3, 1'b0, 64'h5A5A_A5A5_5A5A_A5A5, 5, 32'd4};
        vecs[3] = '{"fast",    64'hCAFE_0000_0000_0001, 64'hBEEF_0000_0000_0002, 0, 1'b0, 64'h1, 0, 32'd1};

        reset            = 1'b1;
        start_valid      = 1'b0;
        start_args       = '0;
        result_ready     = 1'b0;
        done_irq         = 1'b0;
        avs_cra_readdata = poison(0);
        tick();
        tick();
        chk("reset_start_ready", 64'(start_ready), 64'd0);
        chk("reset_busy_valid", {62'd0, busy, result_valid}, 64'd0);
        chk("reset_cra_ctl", {50'd0, avs_cra_read, avs_cra_write, avs_cra_address, avs_cra_byteenable}, 64'd0);
        chk("reset_wdata", avs_cra_writedata, 64'd0);
        chk("reset_result_data", result_data, 64'd0);
        chk("reset_result_misc", {31'd0, result_timeout, result_cycles}, 64'd0);
        reset = 1'b0;
        tick();
        chk("ready_after_reset", 64'(start_ready), 64'd1);

        for (int v = 0; v < 4; v++) begin
            run_txn(vecs[v].nm, vecs[v].a0, vecs[v].a1, vecs[v].d, vecs[v].pre,
                    vecs[v].rdv, vecs[v].hold, vecs[v].exp_cyc, 1'b0);
        end

        reset_mid_arg();
        run_txn("after_reset", 64'h1111, 64'h2222, 2, 1'b0, 64'h3333_4444, 0, 32'd3, 1'b0);

`ifdef CRA_LAUNCH_TIMEOUT_EN
        run_txn("timeout", 64'h9, 64'h8, -1, 1'b0, 64'hAAAA_BBBB, 0, 32'd16, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
